// File: rtl/oam_dma_arbiter.sv
// ---------------------------------------------------------------------------
// oam_dma_arbiter
//
// Bus arbiter and sequencer that sits between the cpu6502 pins and the
// system memory decode. A CPU write to TRIGGER_ADDR latches a source page and
// pulls RDY low. Once the CPU has stalled on a read cycle, the block takes the
// bus. It copies LENGTH bytes from {page, idx} to the fixed DEST_ADDR, using
// alternating read and write cycles.
//
// Every state change is qualified by the cyc strobe, which marks the end of a
// bus cycle. Between strobes the FSM and all of its outputs hold still.
//
// Ports
//   clk        in   1   system clock
//   reset      in   1   asynchronous reset, active-low
//   cyc        in   1   one-clk strobe at the end of each bus cycle
//   cpu_addr   in   16  CPU address bus
//   cpu_odata  in   8   CPU write data
//   cpu_rw     in   1   CPU read(1) / write(0)
//   cpu_rdy    out  1   RDY to CPU, 0 stalls the CPU on its next read
//   mem_addr   out  16  address to memory decode
//   mem_wdata  out  8   write data to memory
//   mem_rw     out  1   read(1) / write(0) to memory
//   mem_rdata  in   8   read data from memory, valid at cyc
//   busy       out  1   1 while DMA owns or is acquiring the bus
//   done       out  1   one-clk pulse when a transfer completes
// ---------------------------------------------------------------------------
module oam_dma_arbiter #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004,
  parameter int unsigned LENGTH       = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cyc,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_odata,
  input  logic        cpu_rw,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rw,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  // The index of the final byte. LENGTH=256 maps to 8'hFF, so idx wraps
  // inside the page and the source never crosses into the next page.
  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  state_t      state_reg;
  logic [7:0]  page_reg;
  logic [7:0]  idx_reg;
  logic [7:0]  data_reg;
  logic        parity_reg;
  logic        cpu_rdy_reg;
  logic        busy_reg;
  logic        done_reg;

  logic        trigger_hit;

  // Only a CPU write to the trigger address starts a transfer.
  // A read of the trigger address is ignored.
  assign trigger_hit = (cpu_rw == 1'b0) && (cpu_addr == TRIGGER_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      page_reg    <= 8'h00;
      idx_reg     <= 8'h00;
      data_reg    <= 8'h00;
      parity_reg  <= 1'b0;
      cpu_rdy_reg <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      // done must be a single-clk pulse even when strobes are sparse.
      // For that reason it clears on every clock, not only on cyc.
      done_reg <= 1'b0;
      if (cyc) begin
        // Free-running parity bit. It tracks the bus-cycle phase, so the
        // first DMA read always falls on the same phase.
        parity_reg <= ~parity_reg;
        case (state_reg)
          IDLE: begin
            if (trigger_hit) begin
              page_reg    <= cpu_odata;
              idx_reg     <= 8'h00;
              busy_reg    <= 1'b1;
              cpu_rdy_reg <= 1'b0;
              state_reg   <= HALT;
            end
          end
          HALT: begin
            // The 6502 ignores RDY during write cycles. The CPU is only
            // truly stalled once it presents a read. Further writes here,
            // including writes to the trigger address, are passed through
            // and do not relatch the page.
            if (cpu_rw) begin
              state_reg <= parity_reg ? ALIGN : READ;
            end
          end
          ALIGN: begin
            state_reg <= READ;
          end
          READ: begin
            data_reg  <= mem_rdata;
            state_reg <= WRITE;
          end
          WRITE: begin
            idx_reg <= idx_reg + 8'd1;
            if (idx_reg == LAST_IDX) begin
              cpu_rdy_reg <= 1'b1;
              busy_reg    <= 1'b0;
              done_reg    <= 1'b1;
              state_reg   <= IDLE;
            end else begin
              state_reg <= READ;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  // Bus mux. The CPU pins pass straight through until the DMA owns the bus.
  // In ALIGN the CPU address is replayed as a harmless dummy read.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_odata;
    mem_rw    = cpu_rw;
    case (state_reg)
      ALIGN: begin
        mem_addr  = cpu_addr;
        mem_wdata = data_reg;
        mem_rw    = 1'b1;
      end
      READ: begin
        mem_addr  = {page_reg, idx_reg};
        mem_wdata = data_reg;
        mem_rw    = 1'b1;
      end
      WRITE: begin
        mem_addr  = DEST_ADDR;
        mem_wdata = data_reg;
        mem_rw    = 1'b0;
      end
      default: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_odata;
        mem_rw    = cpu_rw;
      end
    endcase
  end

  assign cpu_rdy = cpu_rdy_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cyc, cyc4;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_odata;
  logic        cpu_rw;

  logic        cpu_rdy, mem_rw, busy, done;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic        cpu_rdy4, mem_rw4, busy4, done4;
  logic [15:0] mem_addr4;
  logic [7:0]  mem_wdata4, mem_rdata4;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done4_cnt = 0;
  logic p = 1'b0;      // expected parity of the main DUT
  logic p4 = 1'b0;     // expected parity of the LENGTH=4 DUT
  logic sel4 = 1'b0;   // route strobes to the LENGTH=4 DUT

  always #5 clk = ~clk;

  // Memory: each byte is addr_lo ^ addr_hi ^ 8'h59, so page 3 holds i ^ 8'h5A.
  assign mem_rdata  = mem_addr[7:0]  ^ mem_addr[15:8]  ^ 8'h59;
  assign mem_rdata4 = mem_addr4[7:0] ^ mem_addr4[15:8] ^ 8'h59;

  oam_dma_arbiter dut (
    .clk(clk), .reset(reset), .cyc(cyc), .cpu_addr(cpu_addr),
    .cpu_odata(cpu_odata), .cpu_rw(cpu_rw), .cpu_rdy(cpu_rdy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .mem_rdata(mem_rdata), .busy(busy), .done(done)
  );

  oam_dma_arbiter #(.LENGTH(4)) dut4 (
    .clk(clk), .reset(reset), .cyc(cyc4), .cpu_addr(cpu_addr),
    .cpu_odata(cpu_odata), .cpu_rw(cpu_rw), .cpu_rdy(cpu_rdy4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_rw(mem_rw4),
    .mem_rdata(mem_rdata4), .busy(busy4), .done(done4)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change just after the falling edge. Outputs are
  // sampled 1ns later, well before the next rising edge.
  task automatic drive(input logic c, input logic [15:0] a, input logic [7:0] d, input logic rw);
    @(negedge clk);
    done_cnt  += int'(done);
    done4_cnt += int'(done4);
    cpu_addr  = a;
    cpu_odata = d;
    cpu_rw    = rw;
    cyc       = sel4 ? 1'b0 : c;
    cyc4      = sel4 ? c : 1'b0;
    if (c && !sel4) p = ~p;
    if (c && sel4) p4 = ~p4;
    #1;
  endtask

  // Insert a dummy read of the trigger address if needed. This makes the
  // halting read land on parity 'want'. The read must not start anything.
  task automatic prep(input logic want);
    if (p == want) begin
      drive(1'b1, 16'h4014, 8'h00, 1'b1);
      chk("trig_read_busy", busy, 1'b0);
    end
  endtask

  task automatic trigger(input logic [7:0] pg);
    drive(1'b1, 16'h4014, pg, 1'b0);
    chk("trig_addr", mem_addr, 16'h4014);
    chk("trig_rw", mem_rw, 1'b0);
    chk("trig_wdata", mem_wdata, pg);
  endtask

  task automatic run_transfer(input logic [7:0] pg, input int n, input bit full);
    logic al;
    al = p;
    done_cnt = 0;
    drive(1'b1, 16'hE000, 8'h00, 1'b1);
    chk("halt_rdy", cpu_rdy, 1'b0);
    chk("halt_busy", busy, 1'b1);
    chk("halt_addr", mem_addr, 16'hE000);
    if (al) begin
      drive(1'b1, 16'hE001, 8'h00, 1'b1);
      chk("align_addr", mem_addr, 16'hE001);
      chk("align_rw", mem_rw, 1'b1);
    end
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 16'hE002, 8'h00, 1'b1);
      chk("rd_addr", mem_addr, {pg, 8'(i)});
      chk("rd_rw", mem_rw, 1'b1);
      chk("rd_rdy", cpu_rdy, 1'b0);
      drive(1'b1, 16'hE002, 8'h00, 1'b1);
      chk("wr_addr", mem_addr, 16'h2004);
      chk("wr_rw", mem_rw, 1'b0);
      chk("wr_data", mem_wdata, 8'(i) ^ pg ^ 8'h59);
    end
    if (full) begin
      drive(1'b0, 16'hE003, 8'h00, 1'b1);
      chk("end_done", done, 1'b1);
      chk("end_rdy", cpu_rdy, 1'b1);
      chk("end_busy", busy, 1'b0);
      chk("end_addr", mem_addr, 16'hE003);
      drive(1'b0, 16'hE003, 8'h00, 1'b1);
      chk("done_clear", done, 1'b0);
      chk("done_once", 16'(done_cnt), 16'd1);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cyc = 1'b0; cyc4 = 1'b0;
    cpu_addr = 16'h1234; cpu_odata = 8'hAB; cpu_rw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", cpu_rdy, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", mem_addr, 16'h1234);
    chk("rst_wdata", mem_wdata, 8'hAB);
    @(negedge clk) reset = 1'b1;

    // 1: no ALIGN, page $02
    prep(1'b0); trigger(8'h02); run_transfer(8'h02, 256, 1'b1);
    // 2: halt on odd parity, one ALIGN cycle
    prep(1'b1); trigger(8'h02); run_transfer(8'h02, 256, 1'b1);
    // 3: page $03, data i^5A, last read $03FF
    prep(1'b0); trigger(8'h03); run_transfer(8'h03, 256, 1'b1);

    // 4: two CPU writes after the trigger, the second retriggering $07
    prep(1'b0); trigger(8'h02);
    drive(1'b1, 16'h0300, 8'h11, 1'b0);
    chk("w1_addr", mem_addr, 16'h0300);
    chk("w1_wdata", mem_wdata, 8'h11);
    chk("w1_rdy", cpu_rdy, 1'b0);
    drive(1'b1, 16'h4014, 8'h07, 1'b0);
    chk("w2_addr", mem_addr, 16'h4014);
    chk("w2_rw", mem_rw, 1'b0);
    run_transfer(8'h02, 256, 1'b1);

    // 5: reset mid-transfer at byte 100, then a fresh transfer of page $05
    prep(1'b0); trigger(8'h02); run_transfer(8'h02, 100, 1'b0);
    @(posedge clk); #2;
    cpu_addr = 16'h1234; cpu_odata = 8'hAB; cpu_rw = 1'b0; cyc = 1'b0;
    reset = 1'b0; #1;
    chk("abort_rdy", cpu_rdy, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_addr", mem_addr, 16'h1234);
    chk("abort_rw", mem_rw, 1'b0);
    @(negedge clk) reset = 1'b1;
    p = 1'b0; p4 = 1'b0;
    drive(1'b0, 16'h1234, 8'hAB, 1'b0);
    chk("post_addr", mem_addr, 16'h1234);
    chk("post_wdata", mem_wdata, 8'hAB);
    prep(1'b0); trigger(8'h05); run_transfer(8'h05, 256, 1'b1);

    // 6: LENGTH=4, one strobe per three clocks, strobe on the third clock
    sel4 = 1'b1; done4_cnt = 0;
    for (int k = 0; k < 3; k++) drive(k == 2, 16'h8000, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(k == 2, 16'h4014, 8'h06, 1'b0);
      chk("g_trig_addr", mem_addr4, 16'h4014);
    end
    for (int k = 0; k < 3; k++) begin
      drive(k == 2, 16'hE000, 8'h00, 1'b1);
      chk("g_halt_addr", mem_addr4, 16'hE000);
      chk("g_halt_rdy", cpu_rdy4, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) begin
        drive(k == 2, 16'hE000, 8'h00, 1'b1);
        chk("g_rd_addr", mem_addr4, {8'h06, 8'(i)});
        chk("g_busy", busy4, 1'b1);
      end
      for (int k = 0; k < 3; k++) begin
        drive(k == 2, 16'hE000, 8'h00, 1'b1);
        chk("g_wr_addr", mem_addr4, 16'h2004);
        chk("g_wr_data", mem_wdata4, 8'(i) ^ 8'h06 ^ 8'h59);
      end
    end
    for (int k = 0; k < 4; k++) drive(1'b0, 16'hE000, 8'h00, 1'b1);
    chk("g_done_once", 16'(done4_cnt), 16'd1);
    chk("g_end_rdy", cpu_rdy4, 1'b1);
    chk("g_end_busy", busy4, 1'b0);
    chk("g_end_addr", mem_addr4, 16'hE000);
    chk("main_done_quiet", 16'(done_cnt), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
